// File: rtl/accumulator_pkg.sv
// Shared types and defaults for the multi-register accumulator file.
package accumulator_pkg;

  localparam int DEF_WIDTH = 8;
  localparam int DEF_NREGS = 4;

  typedef enum logic [2:0] {
    OP_NOP        = 3'd0,
    OP_LOAD       = 3'd1,
    OP_LOAD_LOWER = 3'd2,
    OP_SHL        = 3'd3,
    OP_SHR        = 3'd4,
    OP_INC        = 3'd5,
    OP_DEC        = 3'd6,
    OP_SHRN       = 3'd7
  } op_e;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_SHIFT = 1'b1
  } state_e;

endpackage

// File: rtl/accumulator_if.sv
// Control/data bundle between the bus sequencer and the accumulator file.
interface accumulator_if #(
  parameter int WIDTH = 8,
  parameter int NREGS = 4
);
  localparam int SW = $clog2(NREGS);

  logic [WIDTH-1:0] BusIn;
  logic [SW-1:0]    Sel;
  logic [2:0]       Op;
  logic             Aout;
  logic [WIDTH-1:0] ALUIn;
  logic             Zero;
  logic             Carry;
  logic             Busy;
  logic             Done;

  modport master (
    output BusIn, Sel, Op, Aout,
    input  ALUIn, Zero, Carry, Busy, Done
  );

  modport slave (
    input  BusIn, Sel, Op, Aout,
    output ALUIn, Zero, Carry, Busy, Done
  );

endinterface

// File: rtl/accumulator_shift_fsm.sv
// Sequencer for the multi-cycle right shift: holds the remaining count and the
// latched target register, and produces Busy, the per-cycle shift strobe and Done.
module accumulator_shift_fsm
  import accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int SW    = 2,
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_i,
  input  logic [CW-1:0] count_i,
  input  logic [SW-1:0] sel_i,
  output logic          busy_o,
  output logic          shift_o,
  output logic          done_o,
  output logic [SW-1:0] tgt_o
);

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [SW-1:0] tgt_q, tgt_d;
  logic          done_q, done_d;
  logic [CW-1:0] k_sat;

  function automatic logic [CW-1:0] sat_count(input logic [CW-1:0] k);
    return (k > CW'(WIDTH)) ? CW'(WIDTH) : k;
  endfunction

  assign k_sat = sat_count(count_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      tgt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      tgt_q   <= tgt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    tgt_d   = tgt_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A zero count is a no-op: never enters SHIFT, so no Busy and no Done.
        if (req_i && (k_sat != '0)) begin
          state_d = ST_SHIFT;
          cnt_d   = k_sat;
          tgt_d   = sel_i;
        end
      end
      ST_SHIFT: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    busy_o  = (state_q == ST_SHIFT);
    shift_o = (state_q == ST_SHIFT);
    done_o  = done_q;
    tgt_o   = tgt_q;
  end

endmodule

// File: rtl/accumulator_file.sv
// NREGS x WIDTH accumulator bank: op decode, register array and output muxing.
// The selected register feeds the ALU continuously and the bus when Aout is set.
module accumulator_file
  import accumulator_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREGS = DEF_NREGS,
  parameter int SW    = $clog2(NREGS),
  parameter int CW    = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  accumulator_if.slave     bus,
  output wire  [WIDTH-1:0] BusOut
);

  logic [WIDTH-1:0] regs_q [NREGS];
  logic [WIDTH-1:0] regs_d [NREGS];
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] cur;
  logic [WIDTH:0]   sum;
  logic             busy, shift_en;
  logic [SW-1:0]    tgt;
  op_e              op;

  assign op  = op_e'(bus.Op);
  assign cur = regs_q[bus.Sel];

  accumulator_shift_fsm #(
    .WIDTH (WIDTH),
    .SW    (SW),
    .CW    (CW)
  ) u_shift_fsm (
    .clk     (clk),
    .rst     (rst),
    .req_i   ((op == OP_SHRN) && !busy),
    .count_i (bus.BusIn[CW-1:0]),
    .sel_i   (bus.Sel),
    .busy_o  (busy),
    .shift_o (shift_en),
    .done_o  (bus.Done),
    .tgt_o   (tgt)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      regs_q  <= '{default: '0};
      carry_q <= 1'b0;
    end else begin
      regs_q  <= regs_d;
      carry_q <= carry_d;
    end
  end

  always_comb begin
    regs_d  = regs_q;
    carry_d = carry_q;
    sum     = {1'b0, cur} + {{WIDTH{1'b0}}, 1'b1};
    // While shifting, Op is dropped and only the latched target moves.
    if (shift_en) begin
      regs_d[tgt] = regs_q[tgt] >> 1;
      carry_d     = regs_q[tgt][0];
    end else begin
      case (op)
        OP_LOAD:       regs_d[bus.Sel] = bus.BusIn;
        OP_LOAD_LOWER: regs_d[bus.Sel] = {{(WIDTH/2){1'b0}}, bus.BusIn[WIDTH/2-1:0]};
        OP_SHL: begin
          regs_d[bus.Sel] = {cur[WIDTH-2:0], 1'b0};
          carry_d         = cur[WIDTH-1];
        end
        OP_SHR: begin
          regs_d[bus.Sel] = {1'b0, cur[WIDTH-1:1]};
          carry_d         = cur[0];
        end
        OP_INC: begin
          regs_d[bus.Sel] = sum[WIDTH-1:0];
          carry_d         = sum[WIDTH];
        end
        OP_DEC: begin
          regs_d[bus.Sel] = cur - {{(WIDTH-1){1'b0}}, 1'b1};
          carry_d         = (cur == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.ALUIn = cur;
  assign bus.Zero  = (cur == '0);
  assign bus.Carry = carry_q;
  assign bus.Busy  = busy;
  assign BusOut    = bus.Aout ? cur : {WIDTH{1'bz}};

endmodule
